// File: rtl/irrigation_pkg.sv
// irrigation_pkg
//   Shared definitions for the irrigation controller front end.
//   - NUM_SENSORS and the channel index of each raw field sensor line
//   - fault_state_e: states of the level-probe ordering fault machine
//   - level_incons(): probe-ordering check on the three tank-level bits
package irrigation_pkg;

    localparam int NUM_SENSORS   = 6;

    localparam int CH_LOW_LEVEL  = 0;
    localparam int CH_MID_LEVEL  = 1;
    localparam int CH_HIGH_LEVEL = 2;
    localparam int CH_EARTH_HUM  = 3;
    localparam int CH_AIR_HUM    = 4;
    localparam int CH_LOW_TEMP   = 5;

    // Fault machine states
    //   state   | meaning
    //   OK      | probes consistent (or not yet valid), no fault
    //   PENDING | probes inconsistent, persistence being timed
    //   FAULT   | inconsistency persisted long enough, fault latched
    typedef enum logic [1:0] {
        OK      = 2'd0,
        PENDING = 2'd1,
        FAULT   = 2'd2
    } fault_state_e;

    // A wet higher probe over a dry lower probe is physically impossible,
    // so it indicates a broken or miswired probe.
    function automatic logic level_incons(input logic low,
                                          input logic mid,
                                          input logic high);
        return (high & ~mid) | (mid & ~low);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   Two-flop synchroniser followed by a stability counter for one raw
//   sensor line. The clean level only adopts a new synchronised value once
//   it has held for STABLE_CYCLES consecutive cycles; any reversion
//   restarts the count.
//
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   raw_in       in   asynchronous raw sensor line
//   clean_out    out  debounced level
//   changed_out  out  one-cycle pulse in the cycle clean_out toggles
module debounce_channel #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic clean_out,
    output logic changed_out
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          meta_q,    meta_d;
    logic          sync_q,    sync_d;
    logic          clean_q,   clean_d;
    logic          changed_q, changed_d;
    logic [CW-1:0] cnt_q,     cnt_d;

    always_comb begin
        meta_d    = raw_in;
        sync_d    = meta_q;
        clean_d   = clean_q;
        changed_d = 1'b0;
        cnt_d     = cnt_q;

        if (sync_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // The terminal compare is what keeps the counter from wrapping.
            clean_d   = sync_q;
            changed_d = 1'b1;
            cnt_d     = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            clean_q   <= 1'b0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            clean_q   <= clean_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign clean_out   = clean_q;
    assign changed_out = changed_q;

endmodule

// File: rtl/sensor_conditioner.sv
// sensor_conditioner
//   Front end of the irrigation controller: synchronises and debounces the
//   six raw field sensor lines, reports when every channel has had time to
//   settle after reset, and latches a tank-level probe ordering fault that
//   persists for FAULT_CYCLES cycles.
//
//   clk             in   system clock, rising edge
//   reset           in   synchronous, active-high reset
//   raw_sensors     in   raw sensor lines, indexed by irrigation_pkg CH_*
//   fault_clear     in   single-cycle request to clear level_fault
//   clean_sensors   out  debounced sensor levels, same indexing
//   sensor_changed  out  one-cycle pulse per bit when that clean bit toggles
//   sensors_valid   out  high once all channels have settled after reset
//   level_fault     out  sticky probe-ordering fault
//
// Fault machine
//   state   | meaning
//   OK      | probes consistent or sensors not yet valid
//   PENDING | inconsistency seen, fcnt counts persistence edges
//   FAULT   | level_fault latched until cleared with consistent probes
module sensor_conditioner
    import irrigation_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned FAULT_CYCLES  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SENSORS-1:0] raw_sensors,
    input  logic                   fault_clear,
    output logic [NUM_SENSORS-1:0] clean_sensors,
    output logic [NUM_SENSORS-1:0] sensor_changed,
    output logic                   sensors_valid,
    output logic                   level_fault
);

    // Startup counter saturates at STABLE_CYCLES+1; valid is taken on the
    // following edge, matching the worst-case debounce latency.
    localparam int SW = $clog2(STABLE_CYCLES + 2);
    localparam logic [SW-1:0] START_ONE  = SW'(1);
    localparam logic [SW-1:0] START_LAST = SW'(STABLE_CYCLES + 1);

    localparam int FW = $clog2(FAULT_CYCLES + 1);
    localparam logic [FW-1:0] FCNT_ONE  = FW'(1);
    localparam logic [FW-1:0] FCNT_TERM = FW'(FAULT_CYCLES);

    logic [NUM_SENSORS-1:0] clean_w;
    logic [NUM_SENSORS-1:0] changed_w;

    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_debounce (
            .clk         (clk),
            .reset       (reset),
            .raw_in      (raw_sensors[gi]),
            .clean_out   (clean_w[gi]),
            .changed_out (changed_w[gi])
        );
    end

    assign clean_sensors  = clean_w;
    assign sensor_changed = changed_w;

    // ---------------------------------------------------------------
    // Startup qualification
    // ---------------------------------------------------------------
    logic [SW-1:0] start_cnt_q, start_cnt_d;
    logic          valid_q,     valid_d;

    always_comb begin
        start_cnt_d = start_cnt_q;
        valid_d     = valid_q;
        if (start_cnt_q == START_LAST) begin
            valid_d = 1'b1;
        end else begin
            start_cnt_d = start_cnt_q + START_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_cnt_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            start_cnt_q <= start_cnt_d;
            valid_q     <= valid_d;
        end
    end

    assign sensors_valid = valid_q;

    // ---------------------------------------------------------------
    // Level probe ordering fault
    // ---------------------------------------------------------------
    logic         incons;
    fault_state_e state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          level_fault_q, level_fault_d;

    assign incons = level_incons(clean_w[CH_LOW_LEVEL],
                                 clean_w[CH_MID_LEVEL],
                                 clean_w[CH_HIGH_LEVEL]);

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;

        if (!valid_q) begin
            // Probes are not trusted until every channel has settled.
            state_d = OK;
            fcnt_d  = '0;
        end else begin
            unique case (state_q)
                OK: begin
                    if (incons) begin
                        fcnt_d = FCNT_ONE;
                        // A one-cycle persistence window faults immediately.
                        if (FCNT_ONE == FCNT_TERM) begin
                            state_d = FAULT;
                        end else begin
                            state_d = PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (!incons) begin
                        state_d = OK;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_ONE;
                        if (fcnt_d == FCNT_TERM) begin
                            state_d = FAULT;
                        end
                    end
                end
                FAULT: begin
                    // Clearing is refused while the probes still disagree.
                    if (fault_clear && !incons) begin
                        state_d = OK;
                        fcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = OK;
                    fcnt_d  = '0;
                end
            endcase
        end

        level_fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= OK;
            fcnt_q        <= '0;
            level_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            level_fault_q <= level_fault_d;
        end
    end

    assign level_fault = level_fault_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
module tb_sensor_conditioner;
    import irrigation_pkg::*;

    localparam int S_TB = 4;
    localparam int F_TB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] raw_sensors;
    logic       fault_clear;
    logic [5:0] clean_sensors;
    logic [5:0] sensor_changed;
    logic       sensors_valid;
    logic       level_fault;

    int n_cmp = 0;
    int n_bad = 0;

    sensor_conditioner #(
        .STABLE_CYCLES (S_TB),
        .FAULT_CYCLES  (F_TB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .raw_sensors    (raw_sensors),
        .fault_clear    (fault_clear),
        .clean_sensors  (clean_sensors),
        .sensor_changed (sensor_changed),
        .sensors_valid  (sensors_valid),
        .level_fault    (level_fault)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Behaviour from the rules: a clean bit flips to v when the synchronised
    // value (raw two edges ago) has been v for the last S_TB edges and v
    // differs from the clean bit. The fault latches when the clean probes
    // have been inconsistent (while valid) for F_TB consecutive edges.
    logic [5:0] hist[$];
    logic [5:0] m_clean, m_chg;
    logic       m_valid, m_fault;
    int         m_since, m_run;

    function automatic logic m_incons(input logic [5:0] c);
        return (c[CH_HIGH_LEVEL] & ~c[CH_MID_LEVEL]) | (c[CH_MID_LEVEL] & ~c[CH_LOW_LEVEL]);
    endfunction

    task automatic model_edge(input logic rst, input logic [5:0] raw, input logic fclr);
        logic inc_b, val_b, all_diff, v;
        int n, idx;
        if (rst) begin
            hist.delete();
            m_clean = '0; m_chg = '0; m_valid = 1'b0; m_fault = 1'b0;
            m_since = 0;  m_run = 0;
            return;
        end
        inc_b = m_incons(m_clean);
        val_b = m_valid;
        hist.push_back(raw);
        while (hist.size() > S_TB + 2) void'(hist.pop_front());
        n = hist.size();
        m_chg = '0;
        for (int ch = 0; ch < 6; ch++) begin
            all_diff = 1'b1;
            for (int j = 0; j < S_TB; j++) begin
                idx = n - 3 - j;
                v = (idx >= 0) ? hist[idx][ch] : 1'b0;
                if (v == m_clean[ch]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_clean[ch] = ~m_clean[ch];
                m_chg[ch]   = 1'b1;
            end
        end
        if (m_since < 1000) m_since++;
        m_valid = (m_since >= S_TB + 2);
        if (val_b && inc_b) m_run++; else m_run = 0;
        if (m_fault) begin
            if (fclr && !inc_b) m_fault = 1'b0;
        end else if (m_run >= F_TB) begin
            m_fault = 1'b1;
        end
    endtask

    function automatic void check(input string nm, input logic [5:0] act, input logic [5:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    task automatic tick(input logic rst, input logic [5:0] raw, input logic fclr);
        reset = rst; raw_sensors = raw; fault_clear = fclr;
        @(posedge clk);
        model_edge(rst, raw, fclr);
        @(negedge clk);
        check("model_clean",   clean_sensors,  m_clean);
        check("model_changed", sensor_changed, m_chg);
        check("model_valid",   {5'b0, sensors_valid}, {5'b0, m_valid});
        check("model_fault",   {5'b0, level_fault},   {5'b0, m_fault});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic [5:0] raw;
        logic       fclr;
        logic [5:0] clean;
        logic [5:0] chg;
        logic       valid;
        logic       fault;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int reps, input logic rst, input logic [5:0] raw,
                                input logic [5:0] clean, input logic [5:0] chg,
                                input logic valid);
        vec_t v;
        v.rst = rst; v.raw = raw; v.fclr = 1'b0;
        v.clean = clean; v.chg = chg; v.valid = valid; v.fault = 1'b0;
        for (int k = 0; k < reps; k++) vecs.push_back(v);
    endfunction

    logic [5:0] r;
    logic       rr, fc;
    int         hold;

    initial begin
        reset = 1'b1; raw_sensors = '0; fault_clear = 1'b0;
        @(negedge clk);

        // Reset and startup: clean and valid appear on edge 6.
        add(2, 1, 6'b000111, 6'b000000, 6'b000000, 0);
        add(5, 0, 6'b000111, 6'b000000, 6'b000000, 0);
        add(1, 0, 6'b000111, 6'b000111, 6'b000111, 1);
        add(1, 0, 6'b000111, 6'b000111, 6'b000000, 1);
        // Earth humidity glitch of 3 cycles is rejected.
        add(3, 0, 6'b001111, 6'b000111, 6'b000000, 1);
        add(4, 0, 6'b000111, 6'b000111, 6'b000000, 1);
        // Held high: adopted on the 6th edge.
        add(5, 0, 6'b001111, 6'b000111, 6'b000000, 1);
        add(1, 0, 6'b001111, 6'b001111, 6'b001000, 1);
        add(1, 0, 6'b001111, 6'b001111, 6'b000000, 1);
        // Air humidity chatter: 1 x3, 0 x1, then 1 held.
        add(3, 0, 6'b011111, 6'b001111, 6'b000000, 1);
        add(1, 0, 6'b001111, 6'b001111, 6'b000000, 1);
        add(5, 0, 6'b011111, 6'b001111, 6'b000000, 1);
        add(1, 0, 6'b011111, 6'b011111, 6'b010000, 1);
        add(1, 0, 6'b011111, 6'b011111, 6'b000000, 1);

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].raw, vecs[i].fclr);
            check("vec_clean",   clean_sensors,  vecs[i].clean);
            check("vec_changed", sensor_changed, vecs[i].chg);
            check("vec_valid",   {5'b0, sensors_valid}, {5'b0, vecs[i].valid});
            check("vec_fault",   {5'b0, level_fault},   {5'b0, vecs[i].fault});
        end

        // Level fault: low=0 mid=1 high=0, persists 8 edges.
        for (int e = 1; e <= 5; e++) tick(0, 6'b011010, 0);
        check("t4_clean_before", clean_sensors, 6'b011111);
        tick(0, 6'b011010, 0);
        check("t4_clean_incons", clean_sensors, 6'b011010);
        check("t4_changed",      sensor_changed, 6'b000101);
        for (int p = 1; p <= F_TB; p++) begin
            tick(0, 6'b011010, 0);
            check("t4_fault_edge", {5'b0, level_fault}, {5'b0, (p == F_TB)});
        end

        // Fault clear refused while inconsistent.
        tick(0, 6'b011010, 1);
        check("t5_clear_refused", {5'b0, level_fault}, 6'b000001);
        for (int e = 1; e <= 6; e++) tick(0, 6'b011011, 0);
        check("t5_clean_ok",  clean_sensors, 6'b011011);
        check("t5_still_set", {5'b0, level_fault}, 6'b000001);
        tick(0, 6'b011011, 0);
        check("t5_no_clear_yet", {5'b0, level_fault}, 6'b000001);
        tick(0, 6'b011011, 1);
        check("t5_cleared", {5'b0, level_fault}, 6'b000000);

        // Repeat run: consistency restored before the window expires.
        for (int e = 1; e <= 6; e++) tick(0, 6'b011010, 0);
        check("t4b_clean_incons", clean_sensors, 6'b011010);
        for (int e = 1; e <= 10; e++) begin
            tick(0, 6'b011011, 0);
            check("t4b_no_fault", {5'b0, level_fault}, 6'b000000);
        end
        check("t4b_clean_ok", clean_sensors, 6'b011011);

        // Reset mid-operation with fault set and a debounce in progress.
        for (int e = 1; e <= 6 + F_TB; e++) tick(0, 6'b011010, 0);
        check("t6_fault_set", {5'b0, level_fault}, 6'b000001);
        for (int e = 1; e <= 3; e++) tick(0, 6'b010010, 0);
        tick(1, 6'b010010, 0);
        check("t6_rst_clean", clean_sensors, 6'b000000);
        check("t6_rst_chg",   sensor_changed, 6'b000000);
        check("t6_rst_flags", {4'b0, sensors_valid, level_fault}, 6'b000000);
        for (int e = 1; e <= 5; e++) begin
            tick(0, 6'b010010, 0);
            check("t6_startup_clean", clean_sensors, 6'b000000);
            check("t6_startup_valid", {5'b0, sensors_valid}, 6'b000000);
        end
        tick(0, 6'b010010, 0);
        check("t6_restart_clean", clean_sensors, 6'b010010);
        check("t6_restart_valid", {5'b0, sensors_valid}, 6'b000001);

        // Randomised stimulus against the model.
        r = 6'b010010;
        for (int blk = 0; blk < 400; blk++) begin
            if ($urandom_range(0, 3) == 0) r[2:0] = 3'($urandom);
            else r = 6'($urandom);
            hold = $urandom_range(1, 10);
            for (int k = 0; k < hold; k++) begin
                rr = ($urandom_range(0, 299) == 0);
                fc = ($urandom_range(0, 9) == 0);
                tick(rr, r, fc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
